// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  // Sequencer states: fetching, held on a cache busywait, or parked until reset.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC_DEF       = 4;
  // Branch offsets are in words; shift by this to get bytes.
  localparam int unsigned WORD_SHIFT       = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC arithmetic: sequential address, branch target and taken decision.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] PC_INC = 32'(PC_INC_DEF)
) (
  input  logic [31:0] pc,
  input  logic [7:0]  offset,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  output logic [31:0] pcadded,
  output logic [31:0] target,
  output logic        taken
);

  logic [31:0] offset_bytes;

  // Sign-extend the word offset, then scale to bytes; all sums wrap modulo 2^32.
  assign offset_bytes = {{24{offset[7]}}, offset} << WORD_SHIFT;
  assign pcadded      = pc + PC_INC;
  assign target       = pcadded + offset_bytes;
  // A jump wins regardless of any branch decoded alongside it; the target is the same.
  assign taken        = jump | (beq & zero) | (bne & ~zero);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: picks sequential, branch/jump or hold every clock, with halt
// state and a saturating retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned PC_INC       = PC_INC_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INSTR_BUSY,
  input  logic             DATA_BUSY,
  input  logic             JUMP,
  input  logic             BEQ,
  input  logic             BNE,
  input  logic             ZERO,
  input  logic [7:0]       OFFSET,
  input  logic             HALT_REQ,
  output logic [31:0]      PC,
  output logic [31:0]      PCADDED,
  output logic             FETCH_EN,
  output logic             STALLED,
  output logic             HALTED,
  output logic [CNT_W-1:0] RETIRED
);

  pc_state_e        state;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] retired_q;
  logic             stalled_q;
  logic             halted_q;
  logic             busy;
  logic             taken;
  logic [31:0]      pcadded;
  logic [31:0]      target;

  assign busy = INSTR_BUSY | DATA_BUSY;

  pc_target_calc #(
    .PC_INC (32'(PC_INC))
  ) u_target_calc (
    .pc      (pc_q),
    .offset  (OFFSET),
    .jump    (JUMP),
    .beq     (BEQ),
    .bne     (BNE),
    .zero    (ZERO),
    .pcadded (pcadded),
    .target  (target),
    .taken   (taken)
  );

  // FSM, PC register, status flags and retired counter, all updated on one edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      pc_q      <= RESET_VECTOR;
      retired_q <= '0;
      stalled_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        // STALL exits with the full RUN update on the same edge, so both share one path.
        RUN, STALL: begin
          if (busy) begin
            state     <= STALL;
            stalled_q <= 1'b1;
          end else begin
            stalled_q <= 1'b0;
            if (~&retired_q) retired_q <= retired_q + 1'b1;
            if (HALT_REQ) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              state <= RUN;
              pc_q  <= taken ? target : pcadded;
            end
          end
        end
        HALT: begin
          // Frozen until reset; every input is ignored.
        end
        default: begin
          state     <= RUN;
          stalled_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch is requested in RUN/STALL and dropped immediately while reset is held.
  assign FETCH_EN = ~RESET & ~halted_q;
  assign PC       = pc_q;
  assign PCADDED  = pcadded;
  assign STALLED  = stalled_q;
  assign HALTED   = halted_q;
  assign RETIRED  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences and
// random stimulus against a behavioural model. A second instance uses a wrapping reset
// vector and a 4-bit counter so wrap and saturation are exercised.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ib, db, jmp, beq, bne, zr, hreq;
  logic [7:0]  off;

  logic [31:0] pc0, pa0, re0;
  logic        fe0, st0, ha0;
  logic [31:0] pc1, pa1;
  logic [3:0]  re1;
  logic        fe1, st1, ha1;

  int errors = 0;
  int nchk   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut0 (
    .CLK(clk), .RESET(rst), .INSTR_BUSY(ib), .DATA_BUSY(db), .JUMP(jmp), .BEQ(beq),
    .BNE(bne), .ZERO(zr), .OFFSET(off), .HALT_REQ(hreq), .PC(pc0), .PCADDED(pa0),
    .FETCH_EN(fe0), .STALLED(st0), .HALTED(ha0), .RETIRED(re0)
  );

  pc_sequencer #(
    .RESET_VECTOR(32'hFFFF_FFFC), .CNT_W(4)
  ) dut1 (
    .CLK(clk), .RESET(rst), .INSTR_BUSY(ib), .DATA_BUSY(db), .JUMP(jmp), .BEQ(beq),
    .BNE(bne), .ZERO(zr), .OFFSET(off), .HALT_REQ(hreq), .PC(pc1), .PCADDED(pa1),
    .FETCH_EN(fe1), .STALLED(st1), .HALTED(ha1), .RETIRED(re1)
  );

  // Reference model: per instance PC, mode (0 run, 1 stall, 2 halt), retired count.
  logic [31:0]     m_pc  [2];
  int              m_st  [2];
  longint unsigned m_ret [2];
  longint unsigned cmax  [2];
  logic [31:0]     rv    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  = rv[i];
      m_st[i]  = 0;
      m_ret[i] = 0;
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    int so;
    so = int'($signed(off));
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 2) continue;
      if (ib || db) begin
        m_st[i] = 1;
        continue;
      end
      if (m_ret[i] < cmax[i]) m_ret[i] = m_ret[i] + 1;
      if (hreq) begin
        m_st[i] = 2;
      end else begin
        m_st[i] = 0;
        if (jmp || (beq && zr) || (bne && !zr)) m_pc[i] = m_pc[i] + 32'd4 + 32'(so * 4);
        else m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic check_models();
    chk("pc0", pc0, m_pc[0]);
    chk("pcadded0", pa0, m_pc[0] + 32'd4);
    chk1("fetch_en0", fe0, m_st[0] != 2);
    chk1("stalled0", st0, m_st[0] == 1);
    chk1("halted0", ha0, m_st[0] == 2);
    chk("retired0", re0, 32'(m_ret[0]));
    chk("pc1", pc1, m_pc[1]);
    chk("pcadded1", pa1, m_pc[1] + 32'd4);
    chk1("fetch_en1", fe1, m_st[1] != 2);
    chk1("stalled1", st1, m_st[1] == 1);
    chk1("halted1", ha1, m_st[1] == 2);
    chk("retired1", {28'b0, re1}, 32'(m_ret[1]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic clear_inputs();
    ib = 0; db = 0; jmp = 0; beq = 0; bne = 0; zr = 0; off = 8'h00; hreq = 0;
  endtask

  // Mid-cycle asynchronous reset pulse; effects must be visible before any clock edge.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc0", pc0, 32'h0000_0000);
    chk("rst_pc1", pc1, 32'hFFFF_FFFC);
    chk1("rst_stalled0", st0, 1'b0);
    chk1("rst_halted0", ha0, 1'b0);
    chk("rst_retired0", re0, 32'h0);
    chk1("rst_fetch_en0", fe0, 1'b0);
    clear_inputs();
    rst = 1'b0;
    #1;
    chk1("rel_fetch_en0", fe0, 1'b1);
    chk1("rel_fetch_en1", fe1, 1'b1);
  endtask

  typedef struct {
    logic        ib, db, j, be, bn, z;
    logic [7:0]  off;
    logic        h;
    logic [31:0] epc;
    logic [31:0] eret;
    logic        est, eha;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic i_b, logic j, logic be, logic bn, logic z, logic [7:0] o,
                              logic h, logic [31:0] epc, logic [31:0] eret, logic est,
                              logic eha);
    vec_t v;
    v.ib = i_b; v.db = 1'b0; v.j = j; v.be = be; v.bn = bn; v.z = z; v.off = o; v.h = h;
    v.epc = epc; v.eret = eret; v.est = est; v.eha = eha;
    return v;
  endfunction

  initial begin
    logic prev_busy;
    rv[0] = 32'h0000_0000;  cmax[0] = 64'h0000_0000_FFFF_FFFF;
    rv[1] = 32'hFFFF_FFFC;  cmax[1] = 64'd15;

    //          ib j  beq bne z  off    h  pc           ret  st ha
    tbl[0]  = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h04,      1,   0, 0);
    tbl[1]  = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h08,      2,   0, 0);
    tbl[2]  = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h0C,      3,   0, 0);
    tbl[3]  = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h10,      4,   0, 0);
    tbl[4]  = mk(0, 0, 1,  0,  1, 8'hFE, 0, 32'h0C,      5,   0, 0);
    tbl[5]  = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h10,      6,   0, 0);
    tbl[6]  = mk(0, 0, 1,  0,  0, 8'hFE, 0, 32'h14,      7,   0, 0);
    tbl[7]  = mk(0, 0, 1,  0,  1, 8'hFE, 0, 32'h10,      8,   0, 0);
    tbl[8]  = mk(0, 0, 0,  1,  0, 8'h03, 0, 32'h20,      9,   0, 0);
    tbl[9]  = mk(1, 1, 0,  0,  0, 8'h02, 0, 32'h20,      9,   1, 0);
    tbl[10] = mk(1, 1, 0,  0,  0, 8'h02, 0, 32'h20,      9,   1, 0);
    tbl[11] = mk(1, 1, 0,  0,  0, 8'h02, 0, 32'h20,      9,   1, 0);
    tbl[12] = mk(1, 1, 0,  0,  0, 8'h02, 0, 32'h20,      9,   1, 0);
    tbl[13] = mk(0, 1, 0,  0,  0, 8'h02, 0, 32'h2C,      10,  0, 0);
    tbl[14] = mk(0, 1, 0,  0,  0, 8'h03, 0, 32'h3C,      11,  0, 0);
    tbl[15] = mk(0, 0, 0,  0,  0, 8'h00, 0, 32'h40,      12,  0, 0);
    tbl[16] = mk(0, 0, 0,  0,  0, 8'h00, 1, 32'h40,      13,  0, 1);

    // Power-on reset.
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("por_pc0", pc0, 32'h0);
    chk("por_pc1", pc1, 32'hFFFF_FFFC);
    chk1("por_fetch_en0", fe0, 1'b0);
    chk("por_retired0", re0, 32'h0);
    rst = 1'b0;
    #1;
    chk1("por_rel_fetch_en0", fe0, 1'b1);

    // Directed vectors.
    for (int k = 0; k < 17; k++) begin
      ib = tbl[k].ib; db = tbl[k].db; jmp = tbl[k].j; beq = tbl[k].be; bne = tbl[k].bn;
      zr = tbl[k].z; off = tbl[k].off; hreq = tbl[k].h;
      step();
      chk($sformatf("vec%0d_pc", k), pc0, tbl[k].epc);
      chk($sformatf("vec%0d_retired", k), re0, tbl[k].eret);
      chk1($sformatf("vec%0d_stalled", k), st0, tbl[k].est);
      chk1($sformatf("vec%0d_halted", k), ha0, tbl[k].eha);
    end

    // Halted: inputs ignored for 10 cycles.
    hreq = 0;
    for (int k = 0; k < 10; k++) begin
      jmp = 1; off = 8'($urandom);
      step();
      chk("halt_pc", pc0, 32'h40);
      chk1("halt_fetch_en", fe0, 1'b0);
      chk1("halt_halted", ha0, 1'b1);
    end
    reset_pulse();

    // Far jump and negative offset wrapping below zero.
    jmp = 1; off = 8'h3F;
    step();
    chk("jump_0x100", pc0, 32'h0000_0100);
    off = 8'h80;
    step();
    chk("neg_wrap", pc0, 32'hFFFF_FF04);

    // Sequential wrap from the top of the address space on the second instance.
    reset_pulse();
    step();
    chk("seq_wrap_pc1", pc1, 32'h0000_0000);

    // Reset during a data-cache stall.
    db = 1;
    step();
    step();
    chk1("dstall_stalled", st0, 1'b1);
    reset_pulse();
    step();
    chk("after_dstall_pc", pc0, 32'h4);
    chk("after_dstall_retired", re0, 32'h1);

    // Random stimulus; decode held stable while a stall is pending.
    prev_busy = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(59) == 0) begin
        reset_pulse();
        prev_busy = 1'b0;
        continue;
      end
      if (!prev_busy) begin
        jmp  = ($urandom_range(5) == 0);
        beq  = ($urandom_range(3) == 0);
        bne  = ($urandom_range(3) == 0);
        zr   = 1'($urandom);
        off  = 8'($urandom);
        hreq = ($urandom_range(39) == 0);
      end
      ib = ($urandom_range(3) == 0);
      db = ($urandom_range(5) == 0);
      prev_busy = ib | db;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule
